// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared opcode, funct, ALU-op and global-state constants for decode
package id_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_PASS = 4'd5
    } alu_op_e;

endpackage

// File: rtl/instruction_decode_register_file.sv
// rtl/instruction_decode_register_file.sv - 2R/1W register file, r0 hardwired to zero, write-first bypass
module register_file #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] ra1_i,
    input  logic [AW-1:0] ra2_i,
    output logic [DW-1:0] rd1_o,
    output logic [DW-1:0] rd2_o,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [DW-1:0] wd_i
);

    logic [DW-1:0] regs_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // A same-cycle writeback wins over the stored value so dependent reads see it immediately.
    always_comb begin
        rd1_o = regs_q[ra1_i];
        if (ra1_i == '0) begin
            rd1_o = '0;
        end else if (we_i && (wa_i == ra1_i)) begin
            rd1_o = wd_i;
        end
    end

    always_comb begin
        rd2_o = regs_q[ra2_i];
        if (ra2_i == '0) begin
            rd2_o = '0;
        end else if (we_i && (wa_i == ra2_i)) begin
            rd2_o = wd_i;
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - decode stage: register read, zero-cycle PC redirect, squash and ID/EX register
module instruction_decode
    import id_pkg::*;
#(
    parameter int DW       = 32,
    parameter int RF_DEPTH = 32,
    parameter int RA_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      curr_state,
    input  logic [DW-1:0]   if_pc,
    input  logic [DW-1:0]   if_ir,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_addr,
    input  logic [DW-1:0]   wb_data,
    output logic            jump,
    output logic            branch,
    output logic            Jal_swit,
    output logic            JR_swit,
    output logic [DW-1:0]   jump_addr,
    output logic [DW-1:0]   branch_addr,
    output logic            ex_valid,
    output logic [DW-1:0]   ex_rs_val,
    output logic [DW-1:0]   ex_rt_val,
    output logic [DW-1:0]   ex_imm,
    output logic [RA_W-1:0] ex_dst,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic            ex_reg_we,
    output logic            ex_link,
    output logic [DW-1:0]   ex_link_addr
);

    logic [5:0]      opcode, funct;
    logic [RA_W-1:0] rs_a, rt_a, rd_a;
    logic [15:0]     imm16;
    logic [DW-1:0]   rs_val, rt_val, imm_ext;
    logic            active, squash_q, squash_d;

    logic            valid_d, reg_we_d, mem_rd_d, mem_wr_d, link_d, alu_src_d, zext_d;
    logic            is_j, is_jal, is_jr, is_beq, is_bne;
    logic [RA_W-1:0] dst_d;
    alu_op_e         alu_op_d;

    assign opcode = if_ir[31:26];
    assign rs_a   = if_ir[25:21];
    assign rt_a   = if_ir[20:16];
    assign rd_a   = if_ir[15:11];
    assign funct  = if_ir[5:0];
    assign imm16  = if_ir[15:0];

    register_file #(.DW(DW), .DEPTH(RF_DEPTH), .AW(RA_W)) u_rf (
        .clk_i (clk),
        .rst_i (rst),
        .ra1_i (rs_a),
        .ra2_i (rt_a),
        .rd1_o (rs_val),
        .rd2_o (rt_val),
        .we_i  (wb_we),
        .wa_i  (wb_addr),
        .wd_i  (wb_data)
    );

    // The word fetched right after a taken redirect is the fall-through and must not execute.
    assign active = (curr_state == ST_RUN) && !squash_q;

    always_comb begin
        valid_d   = 1'b0;
        reg_we_d  = 1'b0;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        link_d    = 1'b0;
        alu_src_d = 1'b0;
        zext_d    = 1'b0;
        dst_d     = '0;
        alu_op_d  = ALU_ADD;
        is_j      = 1'b0;
        is_jal    = 1'b0;
        is_jr     = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        if (active) begin
            unique case (opcode)
                OP_RTYPE: begin
                    unique case (funct)
                        FN_ADD: begin valid_d = 1'b1; reg_we_d = 1'b1; dst_d = rd_a; alu_op_d = ALU_ADD; end
                        FN_SUB: begin valid_d = 1'b1; reg_we_d = 1'b1; dst_d = rd_a; alu_op_d = ALU_SUB; end
                        FN_AND: begin valid_d = 1'b1; reg_we_d = 1'b1; dst_d = rd_a; alu_op_d = ALU_AND; end
                        FN_OR:  begin valid_d = 1'b1; reg_we_d = 1'b1; dst_d = rd_a; alu_op_d = ALU_OR;  end
                        FN_SLT: begin valid_d = 1'b1; reg_we_d = 1'b1; dst_d = rd_a; alu_op_d = ALU_SLT; end
                        FN_JR:  begin valid_d = 1'b1; is_jr = 1'b1; alu_op_d = ALU_PASS; end
                        default: ;
                    endcase
                end
                OP_J:    begin valid_d = 1'b1; is_j = 1'b1; alu_op_d = ALU_PASS; end
                OP_JAL:  begin
                    valid_d = 1'b1; is_jal = 1'b1; reg_we_d = 1'b1; link_d = 1'b1;
                    dst_d = '1; alu_op_d = ALU_PASS;
                end
                OP_BEQ:  begin valid_d = 1'b1; is_beq = 1'b1; alu_op_d = ALU_SUB; end
                OP_BNE:  begin valid_d = 1'b1; is_bne = 1'b1; alu_op_d = ALU_SUB; end
                OP_ADDI: begin valid_d = 1'b1; reg_we_d = 1'b1; dst_d = rt_a; alu_src_d = 1'b1; alu_op_d = ALU_ADD; end
                OP_ANDI: begin valid_d = 1'b1; reg_we_d = 1'b1; dst_d = rt_a; alu_src_d = 1'b1; zext_d = 1'b1; alu_op_d = ALU_AND; end
                OP_ORI:  begin valid_d = 1'b1; reg_we_d = 1'b1; dst_d = rt_a; alu_src_d = 1'b1; zext_d = 1'b1; alu_op_d = ALU_OR; end
                OP_LW:   begin valid_d = 1'b1; reg_we_d = 1'b1; mem_rd_d = 1'b1; dst_d = rt_a; alu_src_d = 1'b1; alu_op_d = ALU_ADD; end
                OP_SW:   begin valid_d = 1'b1; mem_wr_d = 1'b1; dst_d = rt_a; alu_src_d = 1'b1; alu_op_d = ALU_ADD; end
                default: ;
            endcase
        end
    end

    assign imm_ext = zext_d ? {{(DW-16){1'b0}}, imm16} : {{(DW-16){imm16[15]}}, imm16};

    assign jump        = is_j;
    assign Jal_swit    = is_jal;
    assign JR_swit     = is_jr;
    assign branch      = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));
    assign branch_addr = if_pc + {{(DW-18){imm16[15]}}, imm16, 2'b00};
    assign jump_addr   = is_jr ? rs_val :
                         (is_j || is_jal) ? {if_pc[DW-1:DW-4], if_ir[25:0], 2'b00} : '0;
    assign squash_d    = jump || branch || Jal_swit || JR_swit;

    always_ff @(posedge clk) begin
        if (rst) begin
            squash_q     <= 1'b0;
            ex_valid     <= 1'b0;
            ex_rs_val    <= '0;
            ex_rt_val    <= '0;
            ex_imm       <= '0;
            ex_dst       <= '0;
            ex_alu_op    <= '0;
            ex_alu_src   <= 1'b0;
            ex_mem_rd    <= 1'b0;
            ex_mem_wr    <= 1'b0;
            ex_reg_we    <= 1'b0;
            ex_link      <= 1'b0;
            ex_link_addr <= '0;
        end else begin
            squash_q     <= squash_d;
            ex_valid     <= valid_d;
            ex_rs_val    <= rs_val;
            ex_rt_val    <= rt_val;
            ex_imm       <= imm_ext;
            ex_dst       <= dst_d;
            ex_alu_op    <= alu_op_d;
            ex_alu_src   <= alu_src_d;
            ex_mem_rd    <= mem_rd_d;
            ex_mem_wr    <= mem_wr_d;
            ex_reg_we    <= reg_we_d;
            ex_link      <= link_d;
            ex_link_addr <= if_pc;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - directed and randomized checks of instruction_decode against a behavioural model
module tb_instruction_decode;
    import id_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  curr_state;
    logic [31:0] if_pc, if_ir;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        jump, branch, Jal_swit, JR_swit;
    logic [31:0] jump_addr, branch_addr;
    logic        ex_valid;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]  ex_dst;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_we, ex_link;
    logic [31:0] ex_link_addr;

    int n_cmp = 0;
    int n_err = 0;

    bit [31:0] m_rf [32];
    bit        m_sq;

    typedef struct {
        bit        j, br, jal, jr;
        bit [31:0] jaddr, baddr;
        bit        valid, we, mrd, mwr, link, src;
        bit [31:0] rs_v, rt_v, imm, laddr;
        bit [4:0]  dst;
        bit [3:0]  op;
    } exp_t;

    instruction_decode dut (
        .clk(clk), .rst(rst), .curr_state(curr_state), .if_pc(if_pc), .if_ir(if_ir),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .jump(jump), .branch(branch), .Jal_swit(Jal_swit), .JR_swit(JR_swit),
        .jump_addr(jump_addr), .branch_addr(branch_addr),
        .ex_valid(ex_valid), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
        .ex_dst(ex_dst), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_we(ex_reg_we),
        .ex_link(ex_link), .ex_link_addr(ex_link_addr)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] rd_reg(input int a);
        if (a == 0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    // Expected behaviour of the current inputs, written from instruction semantics.
    function automatic exp_t model();
        exp_t e;
        int rs, rt, rd;
        bit [5:0] opc, fn;
        e = '{default: 0};
        opc = if_ir[31:26]; fn = if_ir[5:0];
        rs = int'(if_ir[25:21]); rt = int'(if_ir[20:16]); rd = int'(if_ir[15:11]);
        e.rs_v  = rd_reg(rs);
        e.rt_v  = rd_reg(rt);
        e.imm   = {{16{if_ir[15]}}, if_ir[15:0]};
        e.baddr = if_pc + (e.imm << 2);
        e.laddr = if_pc;
        if (curr_state != 2'b01 || m_sq) return e;
        case (opc)
            6'h00: case (fn)
                6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin
                    e.valid = 1; e.we = 1; e.dst = rd[4:0];
                    e.op = (fn == 6'h20) ? ALU_ADD : (fn == 6'h22) ? ALU_SUB :
                           (fn == 6'h24) ? ALU_AND : (fn == 6'h25) ? ALU_OR : ALU_SLT;
                end
                6'h08: begin e.valid = 1; e.jr = 1; e.jaddr = e.rs_v; e.op = ALU_PASS; end
                default: ;
            endcase
            6'h02, 6'h03: begin
                e.valid = 1; e.op = ALU_PASS;
                e.jaddr = (if_pc & 32'hF000_0000) | ((if_ir & 32'h03FF_FFFF) << 2);
                if (opc == 6'h02) e.j = 1;
                else begin e.jal = 1; e.we = 1; e.dst = 5'd31; e.link = 1; end
            end
            6'h04: begin e.valid = 1; e.op = ALU_SUB; e.br = (e.rs_v == e.rt_v); end
            6'h05: begin e.valid = 1; e.op = ALU_SUB; e.br = (e.rs_v != e.rt_v); end
            6'h08: begin e.valid = 1; e.we = 1; e.dst = rt[4:0]; e.src = 1; e.op = ALU_ADD; end
            6'h0C: begin e.valid = 1; e.we = 1; e.dst = rt[4:0]; e.src = 1; e.op = ALU_AND; e.imm = {16'd0, if_ir[15:0]}; end
            6'h0D: begin e.valid = 1; e.we = 1; e.dst = rt[4:0]; e.src = 1; e.op = ALU_OR;  e.imm = {16'd0, if_ir[15:0]}; end
            6'h23: begin e.valid = 1; e.we = 1; e.mrd = 1; e.dst = rt[4:0]; e.src = 1; e.op = ALU_ADD; end
            6'h2B: begin e.valid = 1; e.mwr = 1; e.src = 1; e.op = ALU_ADD; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic set_in(input bit [1:0] st, input bit [31:0] pc, input bit [31:0] ir,
                          input bit we, input bit [4:0] wa, input bit [31:0] wd);
        curr_state = st; if_pc = pc; if_ir = ir; wb_we = we; wb_addr = wa; wb_data = wd;
    endtask

    // Clocks one edge and moves the model's register file and squash flag along with it.
    task automatic advance();
        exp_t e;
        e = model();
        @(posedge clk);
        if (rst) begin
            foreach (m_rf[i]) m_rf[i] = '0;
            m_sq = 0;
        end else begin
            if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
            m_sq = e.j | e.br | e.jal | e.jr;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(2'b01, 0, 0, 1, 5'd7, 32'hAA);
        advance();
        rst = 1'b1;
        set_in(2'b01, 32'h10, {6'h02, 26'h5}, 0, 0, 0);
        advance();
        n_cmp++;
        if ({ex_valid, ex_rs_val, ex_rt_val, ex_imm, ex_dst, ex_alu_op, ex_alu_src, ex_mem_rd,
             ex_mem_wr, ex_reg_we, ex_link, ex_link_addr} !== '0) begin
            n_err++; $display("FAIL reset_ex: ex_valid=%0b ex_rs_val=%h ex_link_addr=%h, all zero required", ex_valid, ex_rs_val, ex_link_addr);
        end
        rst = 1'b0;
        set_in(2'b01, 0, {6'h00, 5'd7, 5'd0, 5'd8, 5'd0, 6'h25}, 0, 0, 0);
        advance();
        n_cmp++;
        if (ex_rs_val !== 32'd0 || ex_valid !== 1'b1) begin
            n_err++; $display("FAIL reset_rf: ex_rs_val=%h ex_valid=%0b, required 0 and 1", ex_rs_val, ex_valid);
        end
    endtask

    task automatic test_beq_squash();
        set_in(2'b01, 0, 0, 1, 5'd1, 32'd5); advance();
        set_in(2'b01, 0, 0, 1, 5'd2, 32'd5); advance();
        set_in(2'b01, 32'h104, {6'h04, 5'd1, 5'd2, 16'd3}, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({jump, branch, Jal_swit, JR_swit} !== 4'b0100 || branch_addr !== 32'h110) begin
            n_err++; $display("FAIL beq_taken: redirects=%b branch_addr=%h, required 0100 and 00000110", {jump, branch, Jal_swit, JR_swit}, branch_addr);
        end
        advance();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_reg_we !== 1'b0) begin
            n_err++; $display("FAIL beq_ex: ex_valid=%0b ex_reg_we=%0b, required 1 0", ex_valid, ex_reg_we);
        end
        set_in(2'b01, 32'h108, {6'h04, 5'd1, 5'd2, 16'd3}, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({jump, branch, Jal_swit, JR_swit} !== 4'b0000) begin
            n_err++; $display("FAIL squash_redirect: redirects=%b, required 0000", {jump, branch, Jal_swit, JR_swit});
        end
        advance();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_reg_we !== 1'b0) begin
            n_err++; $display("FAIL squash_ex: ex_valid=%0b ex_reg_we=%0b, required 0 0", ex_valid, ex_reg_we);
        end
    endtask

    task automatic test_bne_not_taken();
        set_in(2'b01, 32'h200, {6'h05, 5'd1, 5'd2, 16'd3}, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (branch !== 1'b0) begin
            n_err++; $display("FAIL bne_branch: branch=%0b, required 0", branch);
        end
        advance();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_reg_we !== 1'b0) begin
            n_err++; $display("FAIL bne_ex: ex_valid=%0b ex_reg_we=%0b, required 1 0", ex_valid, ex_reg_we);
        end
        set_in(2'b01, 32'h204, {6'h08, 5'd1, 5'd4, 16'd7}, 0, 0, 0);
        advance();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_reg_we !== 1'b1 || ex_rs_val !== 32'd5 || ex_imm !== 32'd7 || ex_dst !== 5'd4) begin
            n_err++; $display("FAIL bne_next: valid=%0b we=%0b rs=%h imm=%h dst=%0d, required 1 1 5 7 4", ex_valid, ex_reg_we, ex_rs_val, ex_imm, ex_dst);
        end
    endtask

    task automatic test_jal();
        set_in(2'b01, 32'h8, {6'h03, 26'h40}, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({jump, branch, Jal_swit, JR_swit} !== 4'b0010 || jump_addr !== 32'h100) begin
            n_err++; $display("FAIL jal_redirect: redirects=%b jump_addr=%h, required 0010 and 00000100", {jump, branch, Jal_swit, JR_swit}, jump_addr);
        end
        advance();
        n_cmp++;
        if (ex_dst !== 5'd31 || ex_link !== 1'b1 || ex_link_addr !== 32'h8 || ex_reg_we !== 1'b1) begin
            n_err++; $display("FAIL jal_ex: dst=%0d link=%0b link_addr=%h we=%0b, required 31 1 8 1", ex_dst, ex_link, ex_link_addr, ex_reg_we);
        end
        set_in(2'b01, 32'hC, {6'h02, 26'h80}, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (jump !== 1'b0) begin
            n_err++; $display("FAIL jal_squash: jump=%0b, required 0", jump);
        end
        advance();
    endtask

    task automatic test_jr_bypass();
        set_in(2'b01, 32'h300, {6'h00, 5'd3, 15'd0, 6'h08}, 1, 5'd3, 32'hDEADBEEF);
        @(negedge clk);
        n_cmp++;
        if ({jump, branch, Jal_swit, JR_swit} !== 4'b0001 || jump_addr !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL jr_bypass: redirects=%b jump_addr=%h, required 0001 and deadbeef", {jump, branch, Jal_swit, JR_swit}, jump_addr);
        end
        advance();
        set_in(2'b01, 32'h304, 0, 0, 0, 0);
        advance();
    endtask

    task automatic test_r0_and_lw();
        set_in(2'b01, 0, {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 1, 5'd0, 32'h1234);
        advance();
        set_in(2'b01, 4, {6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 6'h25}, 1, 5'd0, 32'h55);
        advance();
        n_cmp++;
        if (ex_rs_val !== 32'd0 || ex_rt_val !== 32'd0 || ex_valid !== 1'b1) begin
            n_err++; $display("FAIL r0_read: rs=%h rt=%h valid=%0b, required 0 0 1", ex_rs_val, ex_rt_val, ex_valid);
        end
        set_in(2'b01, 8, {6'h23, 5'd1, 5'd5, 16'hFFFC}, 0, 0, 0);
        advance();
        n_cmp++;
        if (ex_mem_rd !== 1'b1 || ex_alu_src !== 1'b1 || ex_imm !== 32'hFFFFFFFC || ex_dst !== 5'd5 || ex_reg_we !== 1'b1) begin
            n_err++; $display("FAIL lw_decode: mem_rd=%0b src=%0b imm=%h dst=%0d we=%0b, required 1 1 fffffffc 5 1", ex_mem_rd, ex_alu_src, ex_imm, ex_dst, ex_reg_we);
        end
    endtask

    task automatic test_idle_and_reset_squash();
        set_in(2'b00, 32'h400, {6'h02, 26'h10}, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({jump, branch, Jal_swit, JR_swit} !== 4'b0000) begin
            n_err++; $display("FAIL idle_redirect: redirects=%b, required 0000", {jump, branch, Jal_swit, JR_swit});
        end
        advance();
        n_cmp++;
        if (ex_valid !== 1'b0) begin
            n_err++; $display("FAIL idle_ex: ex_valid=%0b, required 0", ex_valid);
        end
        set_in(2'b01, 32'h500, {6'h03, 26'h20}, 0, 0, 0);
        advance();
        rst = 1'b1;
        advance();
        n_cmp++;
        if ({ex_valid, ex_dst, ex_link, ex_reg_we, ex_link_addr, ex_rs_val} !== '0) begin
            n_err++; $display("FAIL rst_squash_ex: valid=%0b dst=%0d link=%0b link_addr=%h, all zero required", ex_valid, ex_dst, ex_link, ex_link_addr);
        end
        rst = 1'b0;
        set_in(2'b01, 32'h504, {6'h02, 26'h30}, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (jump !== 1'b1 || jump_addr !== 32'hC0) begin
            n_err++; $display("FAIL rst_squash_clear: jump=%0b jump_addr=%h, required 1 000000c0", jump, jump_addr);
        end
        advance();
        set_in(2'b01, 32'h508, 0, 0, 0, 0);
        advance();
    endtask

    function automatic bit [31:0] rand_ir();
        bit [4:0] rs, rt, rd;
        bit [15:0] imm;
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 15))
            0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
            2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
            3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4:  return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            5:  return {6'h00, rs, 15'd0, 6'h08};
            6:  return {6'h02, 26'($urandom)};
            7:  return {6'h03, 26'($urandom)};
            8:  return {6'h04, rs, ($urandom_range(0, 1) != 0) ? rs : rt, imm};
            9:  return {6'h05, rs, ($urandom_range(0, 1) != 0) ? rs : rt, imm};
            10: return {6'h08, rs, rt, imm};
            11: return {6'h0C, rs, rt, imm};
            12: return {6'h0D, rs, rt, imm};
            13: return {6'h23, rs, rt, imm};
            14: return {6'h2B, rs, rt, imm};
            default: return {6'h3F, 26'($urandom)};
        endcase
    endfunction

    task automatic test_random();
        exp_t e;
        rst = 1'b1;
        set_in(2'b00, 0, 0, 0, 0, 0);
        advance();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01, $urandom & 32'hFFFF_FFFC, rand_ir(),
                   1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            @(negedge clk);
            e = model();
            n_cmp++;
            if ({jump, branch, Jal_swit, JR_swit} !== {e.j, e.br, e.jal, e.jr}) begin
                n_err++; $display("FAIL rnd_redirect[%0d]: ir=%h got %b exp %b", i, if_ir, {jump, branch, Jal_swit, JR_swit}, {e.j, e.br, e.jal, e.jr});
            end
            n_cmp++;
            if (branch_addr !== e.baddr) begin
                n_err++; $display("FAIL rnd_baddr[%0d]: got %h exp %h", i, branch_addr, e.baddr);
            end
            if (e.j || e.jal || e.jr) begin
                n_cmp++;
                if (jump_addr !== e.jaddr) begin
                    n_err++; $display("FAIL rnd_jaddr[%0d]: ir=%h got %h exp %h", i, if_ir, jump_addr, e.jaddr);
                end
            end
            advance();
            n_cmp++;
            if ({ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_link} !== {e.valid, e.we, e.mrd, e.mwr, e.link}) begin
                n_err++; $display("FAIL rnd_ctrl[%0d]: ir=%h got %b exp %b", i, if_ir, {ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_link}, {e.valid, e.we, e.mrd, e.mwr, e.link});
            end
            if (e.valid) begin
                n_cmp++;
                if (ex_rs_val !== e.rs_v || ex_rt_val !== e.rt_v || ex_imm !== e.imm || ex_alu_op !== e.op ||
                    ex_alu_src !== e.src || ex_link_addr !== e.laddr) begin
                    n_err++; $display("FAIL rnd_data[%0d]: ir=%h rs %h/%h rt %h/%h imm %h/%h op %0d/%0d src %0b/%0b la %h/%h (got/exp)",
                                      i, if_ir, ex_rs_val, e.rs_v, ex_rt_val, e.rt_v, ex_imm, e.imm, ex_alu_op, e.op,
                                      ex_alu_src, e.src, ex_link_addr, e.laddr);
                end
            end
            if (e.we) begin
                n_cmp++;
                if (ex_dst !== e.dst) begin
                    n_err++; $display("FAIL rnd_dst[%0d]: ir=%h got %0d exp %0d", i, if_ir, ex_dst, e.dst);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        m_sq = 0;
        foreach (m_rf[i]) m_rf[i] = '0;
        set_in(2'b00, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_beq_squash();
        test_bne_not_taken();
        test_jal();
        test_jr_bypass();
        test_r0_and_lw();
        test_idle_and_reset_squash();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
